// File: rtl/data_stream_stats_pkg.sv
// Shared constants and FSM state encoding for the data ROM and its consumers.
`default_nettype none

package data_stream_stats_pkg;

  localparam int DEF_NUM_ENTRIES = 11;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_IDX_W       = 4;
  localparam int DEF_SUM_W       = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/data_stream_stats.sv
// Walks the data ROM once per start pulse and keeps the signed sum, minimum and maximum.
`default_nettype none

module data_stream_stats
  import data_stream_stats_pkg::*;
#(
  parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int SUM_W       = DEF_SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  data_index,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [DATA_W-1:0] MIN_INIT = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [SUM_W-1:0]   r_sum;
  logic [DATA_W-1:0]  r_min;
  logic [DATA_W-1:0]  r_max;
  logic [SUM_W-1:0]   w_ext;
  logic               w_last;
  logic               w_lt_min;
  logic               w_gt_max;

  assign w_ext    = {{(SUM_W-DATA_W){data_in[DATA_W-1]}}, data_in};
  assign w_last   = (r_idx == LAST_IDX);
  assign w_lt_min = $signed(data_in) < $signed(r_min);
  assign w_gt_max = $signed(data_in) > $signed(r_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_READ;
      ST_READ: if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Results are only rewritten at run start and during READ, so they hold elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx <= '0;
            r_sum <= '0;
            r_min <= MIN_INIT;
            r_max <= MAX_INIT;
          end
        end
        ST_READ: begin
          r_sum <= r_sum + w_ext;
          if (w_lt_min) r_min <= data_in;
          if (w_gt_max) r_max <= data_in;
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign data_index = r_idx;
  assign busy       = (r_state == ST_READ) || (r_state == ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign sum        = r_sum;
  assign min_val    = r_min;
  assign max_val    = r_max;

endmodule

`default_nettype wire

// File: tb/tb_data_stream_stats.sv
// Directed bench for data_stream_stats with a combinational ROM model whose contents vary per test.
`default_nettype none

module tb_data_stream_stats;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  data_index;
  logic [7:0]  data_in;
  logic        busy;
  logic        done;
  logic [11:0] sum;
  logic [7:0]  min_val;
  logic [7:0]  max_val;

  logic [10:0][7:0] rom;
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int idx_oob  = 0;

  data_stream_stats dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .data_index (data_index),
    .data_in    (data_in),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .min_val    (min_val),
    .max_val    (max_val)
  );

  assign data_in = (data_index < 4'd11) ? rom[data_index] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (data_index > 4'd10) idx_oob++;
  end

  typedef struct {
    string            name;
    logic [10:0][7:0] contents;
    logic [11:0]      esum;
    logic [7:0]       emin;
    logic [7:0]       emax;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issues a one-cycle start, follows the index sequence and checks the done cycle.
  task automatic run_check(input string nm, input logic [11:0] esum,
                           input logic [7:0] emin, input logic [7:0] emax);
    int bad_idx;
    int d0;
    bad_idx = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    d0 = done_cnt;
    check({nm, " busy_run"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < 11; k++) begin
      if (data_index !== 4'(k) || done !== 1'b0) bad_idx++;
      @(negedge clk);
    end
    check({nm, " index_seq_errs"}, bad_idx, 0);
    check({nm, " done"}, {30'd0, done, busy}, 32'd3);
    check({nm, " sum"}, {20'd0, sum}, {20'd0, esum});
    check({nm, " min"}, {24'd0, min_val}, {24'd0, emin});
    check({nm, " max"}, {24'd0, max_val}, {24'd0, emax});
    @(negedge clk);
    check({nm, " idle_after"}, {30'd0, done, busy}, 32'd0);
    check({nm, " done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    int bad;
    int wait_cyc;

    vecs[0] = '{"mixed_ext", {8'h0C, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h7F, 8'h80, 8'h7F, 8'h80},
                12'h010, 8'h80, 8'h7F};
    vecs[1] = '{"all_80", {11{8'h80}}, 12'hA80, 8'h80, 8'h80};
    vecs[2] = '{"all_7F", {11{8'h7F}}, 12'h575, 8'h7F, 8'h7F};
    vecs[3] = '{"ascend", {8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00},
                12'h037, 8'h00, 8'h0A};
    vecs[4] = '{"all_FF", {11{8'hFF}}, 12'hFF5, 8'hFF, 8'hFF};
    vecs[5] = '{"signed_mix", {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hF0, 8'h10, 8'h00, 8'hFB, 8'h05},
                12'h015, 8'hF0, 8'h10};

    rst_n = 1'b0;
    start = 1'b0;
    rom   = vecs[0].contents;
    #23;
    check("reset_outputs", {data_index, busy, done, sum, min_val, max_val}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt, 0);

    for (int v = 0; v < 6; v++) begin
      rom = vecs[v].contents;
      run_check(vecs[v].name, vecs[v].esum, vecs[v].emin, vecs[v].emax);
    end

    // Results must hold with start low for a long idle stretch.
    bad = 0;
    d0 = done_cnt;
    rom = vecs[0].contents;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sum !== 12'h015 || min_val !== 8'hF0 || max_val !== 8'h10 || busy !== 1'b0) bad++;
    end
    check("hold_idle_errs", bad, 0);
    check("hold_idle_no_done", done_cnt - d0, 0);

    // Async reset mid-cycle with non-zero results present.
    #2 rst_n = 1'b0;
    #1 check("async_reset", {data_index, busy, done, sum, min_val, max_val}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Start held high across a whole run: one done, then a new run right after DONE.
    rom = vecs[0].contents;
    d0 = done_cnt;
    @(negedge clk); start = 1'b1;
    wait_cyc = 0;
    while (done !== 1'b1 && wait_cyc < 30) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("hold_start_done_cycle", wait_cyc, 12);
    check("hold_start_sum", {20'd0, sum}, 32'h010);
    @(negedge clk);
    check("hold_start_idle_gap", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("hold_start_restart", {27'd0, busy, data_index}, {27'd0, 1'b1, 4'd0});
    check("hold_start_one_done", done_cnt - d0, 1);
    wait_cyc = 0;
    while (done !== 1'b1 && wait_cyc < 30) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("restart_done_cycle", wait_cyc, 11);
    check("restart_results", {8'd0, sum, min_val, max_val}, {8'd0, 12'h010, 8'h80, 8'h7F});

    // Reset in the middle of a run discards the partial result.
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_cyc = 0;
    while (data_index !== 4'd5 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("midrun_reach_idx5", wait_cyc, 5);
    #2 rst_n = 1'b0;
    #1 check("midrun_reset", {data_index, busy, done, sum, min_val, max_val}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrun_no_done", done_cnt - d0, 0);
    check("midrun_stays_zero", {18'd0, busy, sum}, 0);
    run_check("after_reset", 12'h010, 8'h80, 8'h7F);

    check("index_never_oob", idx_oob, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
